// File: rtl/race_pkg.sv
// Shared definitions for the race sequencer and the Ethernet rx/tx packet blocks.
// Holds the game state codes, field widths and packet bit offsets.
package race_pkg;

   localparam int GAME_STAT_W = 3;
   localparam int COORD_W     = 11;

   typedef enum logic [GAME_STAT_W-1:0] {
      GS_IDLE      = 3'd0,
      GS_READY     = 3'd1,
      GS_COUNTDOWN = 3'd2,
      GS_RACE      = 3'd3,
      GS_DONE      = 3'd4
   } game_stat_t;

   // Packet layout: {reset, game, dir, y, x}, LSB first.
   localparam int PKT_X_OFS     = 0;
   localparam int PKT_Y_OFS     = PKT_X_OFS + COORD_W;
   localparam int PKT_DIR_OFS   = PKT_Y_OFS + COORD_W;
   localparam int PKT_DIR_W     = 2;
   localparam int PKT_GAME_OFS  = PKT_DIR_OFS + PKT_DIR_W;
   localparam int PKT_RESET_OFS = PKT_GAME_OFS + GAME_STAT_W;
   localparam int PKT_W         = PKT_RESET_OFS + 1;

   function automatic logic in_window(input logic [COORD_W-1:0] v,
                                      input logic [COORD_W-1:0] lo,
                                      input logic [COORD_W-1:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/tx_scheduler.sv
// Transmit request scheduler: one request per FRAME_DIV frames plus one per state change,
// coalesced into a single level request that is held until the transmitter acknowledges it.
module tx_scheduler #(
   parameter int unsigned FRAME_DIV = 1
) (
   input  logic clk_in,
   input  logic rst_in_n,
   input  logic frame_tick_in,
   input  logic state_changed_in,
   input  logic tx_ack_in,
   output logic tx_req_out
);

   localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

   logic [DIV_W-1:0] div_q;
   logic             frame_event;
   logic             any_event;
   logic             req_q;

   assign frame_event = frame_tick_in && (div_q == DIV_LAST);
   assign any_event   = frame_event || state_changed_in;

   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         div_q <= '0;
      end else if (frame_tick_in) begin
         div_q <= frame_event ? '0 : div_q + 1'b1;
      end
   end

   // A new event wins over an acknowledge in the same cycle, so the request re-arms.
   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         req_q <= 1'b0;
      end else begin
         req_q <= any_event || (req_q && !tx_ack_in);
      end
   end

   assign tx_req_out = req_q;

endmodule

// File: rtl/race_controller.sv
// Two-player race sequencer: link supervision, countdown, lap counting and
// the game state broadcast to the peer through the transmit scheduler.
module race_controller
   import race_pkg::*;
#(
   parameter int unsigned         FRAME_DIV    = 1,
   parameter int unsigned         COUNT_FRAMES = 60,
   parameter int unsigned         LAPS         = 3,
   parameter int unsigned         PEER_TIMEOUT = 120,
   parameter logic [COORD_W-1:0]  FINISH_Y     = 11'd400,
   parameter logic [COORD_W-1:0]  FINISH_X_LO  = 11'd128,
   parameter logic [COORD_W-1:0]  FINISH_X_HI  = 11'd256,
   parameter logic [COORD_W-1:0]  HALF_X       = 11'd512
) (
   input  logic                   clk_in,
   input  logic                   rst_in_n,
   input  logic                   start_in,
   input  logic                   frame_tick_in,
   input  logic                   rx_valid_in,
   input  logic [GAME_STAT_W-1:0] rx_game_in,
   input  logic                   rx_reset_in,
   input  logic [COORD_W-1:0]     player_x_in,
   input  logic [COORD_W-1:0]     player_y_in,
   input  logic                   tx_ack_in,
   output logic                   tx_req_out,
   output logic [GAME_STAT_W-1:0] game_stat_out,
   output logic                   move_en_out,
   output logic [1:0]             count_out,
   output logic [1:0]             lap_out,
   output logic                   win_out,
   output logic                   link_ok_out
);

   localparam int CD_W   = (COUNT_FRAMES > 1) ? $clog2(COUNT_FRAMES) : 1;
   localparam int LINK_W = $clog2(PEER_TIMEOUT + 1);
   localparam logic [CD_W-1:0]   CD_LAST  = CD_W'(COUNT_FRAMES - 1);
   localparam logic [LINK_W-1:0] LINK_MAX = LINK_W'(PEER_TIMEOUT);
   localparam logic [1:0]        LAPS_V   = 2'(LAPS);

   game_stat_t             state_q, state_d;
   logic [GAME_STAT_W-1:0] peer_stat_q;
   logic [1:0]             count_q, count_d;
   logic [1:0]             lap_q, lap_d;
   logic                   win_q, win_d;
   logic                   chk_q, chk_d;
   logic [CD_W-1:0]        cd_q, cd_d;
   logic [COORD_W-1:0]     prev_y_q;
   logic [LINK_W-1:0]      link_cnt_q, link_cnt_d;
   logic                   link_ok_q, link_ok_d;
   logic                   crossing;
   logic                   abort;
   logic                   state_changed;

   // Opponent fields and the finish-line history only move on their strobes.
   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         peer_stat_q <= '0;
         prev_y_q    <= '0;
      end else begin
         if (rx_valid_in)   peer_stat_q <= rx_game_in;
         if (frame_tick_in) prev_y_q    <= player_y_in;
      end
   end

   // Frames since the last peer packet; a packet in a tick cycle still clears it.
   always_comb begin
      link_cnt_d = link_cnt_q;
      if (rx_valid_in) begin
         link_cnt_d = '0;
      end else if (frame_tick_in && (link_cnt_q != LINK_MAX)) begin
         link_cnt_d = link_cnt_q + 1'b1;
      end
      link_ok_d = rx_valid_in || (link_ok_q && (link_cnt_d != LINK_MAX));
   end

   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         link_cnt_q <= '0;
         link_ok_q  <= 1'b0;
      end else begin
         link_cnt_q <= link_cnt_d;
         link_ok_q  <= link_ok_d;
      end
   end

   assign crossing = frame_tick_in
                  && (prev_y_q < FINISH_Y)
                  && (player_y_in >= FINISH_Y)
                  && in_window(player_x_in, FINISH_X_LO, FINISH_X_HI);

   assign abort = (rx_valid_in && rx_reset_in)
               || (!link_ok_q && ((state_q == GS_COUNTDOWN) || (state_q == GS_RACE)));

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      lap_d   = lap_q;
      win_d   = win_q;
      chk_d   = chk_q;
      cd_d    = cd_q;
      if (abort) begin
         state_d = GS_IDLE;
         count_d = '0;
         lap_d   = '0;
         win_d   = 1'b0;
         chk_d   = 1'b0;
         cd_d    = '0;
      end else begin
         unique case (state_q)
            GS_IDLE: begin
               if (start_in) state_d = GS_READY;
            end
            GS_READY: begin
               if ((peer_stat_q >= GS_READY) && link_ok_q) begin
                  state_d = GS_COUNTDOWN;
                  count_d = 2'd3;
                  cd_d    = '0;
               end
            end
            GS_COUNTDOWN: begin
               if (frame_tick_in) begin
                  if (cd_q == CD_LAST) begin
                     cd_d = '0;
                     if (count_q == 2'd1) begin
                        state_d = GS_RACE;
                        count_d = '0;
                        chk_d   = 1'b0;
                     end else begin
                        count_d = count_q - 1'b1;
                     end
                  end else begin
                     cd_d = cd_q + 1'b1;
                  end
               end
            end
            GS_RACE: begin
               if (frame_tick_in) begin
                  if (player_x_in >= HALF_X) chk_d = 1'b1;
                  if (crossing && chk_q) begin
                     lap_d = lap_q + 1'b1;
                     chk_d = 1'b0;
                     if ((lap_q + 2'd1) == LAPS_V) begin
                        state_d = GS_DONE;
                        win_d   = (peer_stat_q != GS_DONE);
                     end
                  end
               end
               // The peer finishing first ends our race as a loss.
               if (peer_stat_q == GS_DONE) begin
                  state_d = GS_DONE;
                  win_d   = 1'b0;
               end
            end
            GS_DONE: begin
               if (start_in) begin
                  state_d = GS_IDLE;
                  lap_d   = '0;
                  win_d   = 1'b0;
               end
            end
            default: state_d = GS_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         state_q <= GS_IDLE;
         count_q <= '0;
         lap_q   <= '0;
         win_q   <= 1'b0;
         chk_q   <= 1'b0;
         cd_q    <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         lap_q   <= lap_d;
         win_q   <= win_d;
         chk_q   <= chk_d;
         cd_q    <= cd_d;
      end
   end

   assign state_changed = (state_d != state_q);

   tx_scheduler #(
      .FRAME_DIV(FRAME_DIV)
   ) u_tx_scheduler (
      .clk_in          (clk_in),
      .rst_in_n        (rst_in_n),
      .frame_tick_in   (frame_tick_in),
      .state_changed_in(state_changed),
      .tx_ack_in       (tx_ack_in),
      .tx_req_out      (tx_req_out)
   );

   assign game_stat_out = state_q;
   assign move_en_out   = (state_q == GS_RACE);
   assign count_out     = count_q;
   assign lap_out       = lap_q;
   assign win_out       = win_q;
   assign link_ok_out   = link_ok_q;

endmodule
